// File: rtl/mm_seq_pkg.sv
// Shared types and helpers for the 2x2 signed matrix-multiply sequencer.
// Packed matrices are {m00,m01,m10,m11}, m00 in the top two bits.
package mm_seq_pkg;
  localparam int ELEM_W = 2;
  localparam int SUM_W  = 5;
  localparam int PROD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC0 = 2'd1,
    ST_MAC1 = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Element (r,c) of a packed matrix byte, returned as raw two's-complement bits.
  function automatic logic [ELEM_W-1:0] unpack_elem(input logic [7:0] pm, input logic r,
                                                    input logic c);
    logic [7:0] shifted;
    shifted = pm >> (3'd6 - {r, c, 1'b0});
    return shifted[ELEM_W-1:0];
  endfunction
endpackage

// File: rtl/mm_mac.sv
// Shared signed 2x2-bit multiply-accumulate unit. sum is the value the
// accumulator takes on an enabled edge: the bare product when clr, else acc+product.
module mm_mac
  import mm_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [SUM_W-1:0]  sum
);
  logic [SUM_W-1:0]         acc_r;
  logic signed [PROD_W-1:0] prod_s;

  // Product and accumulate-or-load selection.
  always_comb begin
    prod_s = PROD_W'($signed(a)) * PROD_W'($signed(b));
    if (clr) begin
      sum = SUM_W'(prod_s);
    end else begin
      sum = acc_r + SUM_W'(prod_s);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {SUM_W{1'b0}};
    end else if (en) begin
      acc_r <= sum;
    end
  end
endmodule

// File: rtl/mm_seq_ctrl.sv
// Sequencer for the 2x2 signed matrix multiplier: one shared MAC, C streamed out
// under valid/ready. Define MM_SEQ_ACCUM_EN for the saturating C accumulator and acc_clr.
module mm_seq_ctrl
  import mm_seq_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [7:0]       a_in,
  input  logic [7:0]       b_in,
`ifdef MM_SEQ_ACCUM_EN
  input  logic             acc_clr,
`endif
  output logic             busy,
  output logic             c_valid,
  input  logic             c_ready,
  output logic [OUT_W-1:0] c_data,
  output logic [1:0]       c_idx,
  output logic             c_last,
  output logic             done
);
  state_t           state_r, state_nx_s;
  logic [1:0]       k_r, k_nx_s;
  logic [7:0]       a_r, a_nx_s, b_r, b_nx_s;
  logic             busy_r, busy_nx_s, c_valid_r, c_valid_nx_s;
  logic             c_last_r, c_last_nx_s, done_r, done_nx_s;
  logic [OUT_W-1:0] c_data_r, c_data_nx_s;
  logic [1:0]       c_idx_r, c_idx_nx_s;
  logic             mac_en_s, mac_clr_s, kk_s;
  logic [ELEM_W-1:0] mac_a_s, mac_b_s;
  logic [SUM_W-1:0] mac_sum_s;
  logic [OUT_W-1:0] result_s;

  // Inner-product term kk of element {i,j}={k[1],k[0]}: A[i][kk] * B[kk][j].
  always_comb begin
    mac_a_s = unpack_elem(a_r, k_r[1], kk_s);
    mac_b_s = unpack_elem(b_r, kk_s, k_r[0]);
  end

  mm_mac u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (mac_clr_s),
    .en   (mac_en_s),
    .a    (mac_a_s),
    .b    (mac_b_s),
    .sum  (mac_sum_s)
  );

`ifdef MM_SEQ_ACCUM_EN
  logic [OUT_W-1:0] c_reg_r [4];

  function automatic logic [OUT_W-1:0] sat_add(input logic [OUT_W-1:0] prev,
                                               input logic [SUM_W-1:0] inc);
    logic [OUT_W:0] s;
    s = (OUT_W+1)'($signed(prev)) + (OUT_W+1)'($signed(inc));
    if (s[OUT_W] != s[OUT_W-1]) begin
      return s[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      return s[OUT_W-1:0];
    end
  endfunction

  assign result_s = sat_add(c_reg_r[k_r], mac_sum_s);

  // C register file: cleared only from IDLE, written as each element completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) c_reg_r[i] <= {OUT_W{1'b0}};
    end else if (ena && (state_r == ST_IDLE) && acc_clr) begin
      for (int i = 0; i < 4; i++) c_reg_r[i] <= {OUT_W{1'b0}};
    end else if (ena && (state_r == ST_MAC1)) begin
      c_reg_r[k_r] <= result_s;
    end
  end
`else
  assign result_s = OUT_W'($signed(mac_sum_s));
`endif

  // Next-state and next-output logic; ena low holds everything.
  always_comb begin
    state_nx_s   = state_r;
    k_nx_s       = k_r;
    a_nx_s       = a_r;
    b_nx_s       = b_r;
    busy_nx_s    = busy_r;
    c_valid_nx_s = c_valid_r;
    c_data_nx_s  = c_data_r;
    c_idx_nx_s   = c_idx_r;
    c_last_nx_s  = c_last_r;
    done_nx_s    = done_r;
    mac_en_s     = 1'b0;
    mac_clr_s    = 1'b0;
    kk_s         = 1'b0;
    if (ena) begin
      done_nx_s = 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_nx_s     = a_in;
            b_nx_s     = b_in;
            k_nx_s     = 2'd0;
            busy_nx_s  = 1'b1;
            state_nx_s = ST_MAC0;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_MAC0: begin
          mac_en_s   = 1'b1;
          mac_clr_s  = 1'b1;
          state_nx_s = ST_MAC1;
        end
        ST_MAC1: begin
          mac_en_s     = 1'b1;
          kk_s         = 1'b1;
          c_valid_nx_s = 1'b1;
          c_data_nx_s  = result_s;
          c_idx_nx_s   = k_r;
          c_last_nx_s  = (k_r == 2'd3);
          state_nx_s   = ST_OUT;
        end
        ST_OUT: begin
          if (c_ready) begin
            c_valid_nx_s = 1'b0;
            c_last_nx_s  = 1'b0;
            if (k_r == 2'd3) begin
              done_nx_s  = 1'b1;
              busy_nx_s  = 1'b0;
              state_nx_s = ST_IDLE;
            end else begin
              k_nx_s     = k_r + 2'd1;
              state_nx_s = ST_MAC0;
            end
          end else begin
            state_nx_s = ST_OUT;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // State, operand and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      k_r       <= 2'd0;
      a_r       <= 8'd0;
      b_r       <= 8'd0;
      busy_r    <= 1'b0;
      c_valid_r <= 1'b0;
      c_data_r  <= {OUT_W{1'b0}};
      c_idx_r   <= 2'd0;
      c_last_r  <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      k_r       <= k_nx_s;
      a_r       <= a_nx_s;
      b_r       <= b_nx_s;
      busy_r    <= busy_nx_s;
      c_valid_r <= c_valid_nx_s;
      c_data_r  <= c_data_nx_s;
      c_idx_r   <= c_idx_nx_s;
      c_last_r  <= c_last_nx_s;
      done_r    <= done_nx_s;
    end
  end

  assign busy    = busy_r;
  assign c_valid = c_valid_r;
  assign c_data  = c_data_r;
  assign c_idx   = c_idx_r;
  assign c_last  = c_last_r;
  assign done    = done_r;
endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Scoreboard bench for mm_seq_ctrl: a matrix-arithmetic model queues expected C
// elements per job; a negedge monitor checks every handshake and output stability.
`timescale 1ns/1ps
module tb_mm_seq_ctrl;
  localparam int OUT_W = 8;

  logic clk = 1'b0, rst_n = 1'b1, ena = 1'b0, start = 1'b0, c_ready = 1'b0;
  logic [7:0] a_in = 8'd0, b_in = 8'd0;
`ifdef MM_SEQ_ACCUM_EN
  logic acc_clr = 1'b0;
  int   creg [4];
`endif
  logic busy, c_valid, c_last, done;
  logic [OUT_W-1:0] c_data;
  logic [1:0] c_idx;

  mm_seq_ctrl #(.OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .a_in(a_in), .b_in(b_in),
`ifdef MM_SEQ_ACCUM_EN
    .acc_clr(acc_clr),
`endif
    .busy(busy), .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
    .c_idx(c_idx), .c_last(c_last), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [1:0]       idx;
    logic             last;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0, n_fail = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int elem(input logic [7:0] p, input int r, input int c);
    int v;
    v = int'((p >> (6 - 2 * (2 * r + c))) & 8'd3);
    if (v >= 2) v -= 4;
    return v;
  endfunction

  // Expected C = A*B (optionally saturated onto the running C) for one job.
  task automatic model_job(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int s;
    for (int idx = 0; idx < 4; idx++) begin
      s = elem(a, idx / 2, 0) * elem(b, 0, idx % 2) + elem(a, idx / 2, 1) * elem(b, 1, idx % 2);
`ifdef MM_SEQ_ACCUM_EN
      s = creg[idx] + s;
      if (s > (1 << (OUT_W - 1)) - 1) s = (1 << (OUT_W - 1)) - 1;
      if (s < -(1 << (OUT_W - 1))) s = -(1 << (OUT_W - 1));
      creg[idx] = s;
`endif
      e.data = OUT_W'(s);
      e.idx  = 2'(idx);
      e.last = (idx == 3);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: handshakes pop the scoreboard; stalled outputs must hold.
  logic hold_chk = 1'b0, held_last = 1'b0;
  logic [OUT_W-1:0] held_data = '0;
  logic [1:0] held_idx = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_chk <= 1'b0;
    end else begin
      if (hold_chk) begin
        check("hold_valid", 32'(c_valid), 32'd1);
        check("hold_data", 32'(c_data), 32'(held_data));
        check("hold_idx", 32'(c_idx), 32'(held_idx));
        check("hold_last", 32'(c_last), 32'(held_last));
      end
      if (c_valid && ena && c_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: idx %0d data %0h with empty scoreboard", c_idx, c_data);
        end else begin
          check("c_data", 32'(c_data), 32'(exp_q[0].data));
          check("c_idx", 32'(c_idx), 32'(exp_q[0].idx));
          check("c_last", 32'(c_last), 32'(exp_q[0].last));
          exp_q.delete(0);
        end
      end
      hold_chk  <= c_valid && !(ena && c_ready);
      held_data <= c_data;
      held_idx  <= c_idx;
      held_last <= c_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; start = 1'b0; ena = 1'b0; c_ready = 1'b0;
    repeat (2) tick();
    exp_q.delete();
`ifdef MM_SEQ_ACCUM_EN
    for (int i = 0; i < 4; i++) creg[i] = 0;
`endif
    rst_n = 1'b1;
    tick();
  endtask

  // One job: stall_idx/stall_len backpressure, ena low for freeze_len cycles from MAC1
  // of c00, random c_ready, optional start pulse mid-job, optional fixed latency.
  task automatic run_job(input logic [7:0] a, input logic [7:0] b, input int stall_idx,
                         input int stall_len, input int freeze_len, input bit rand_rdy,
                         input bit poke_start, input int exp_lat);
    int t, stalls, scnt, acc_cyc;
    bit fin;
    model_job(a, b);
    a_in = a; b_in = b; start = 1'b1; ena = 1'b1; c_ready = 1'b1;
    tick();
    acc_cyc = cyc;
    start = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_valid", 32'(c_valid), 32'd0);
    check("accept_done", 32'(done), 32'd0);
    t = 0; stalls = 0; scnt = 0; fin = 1'b0;
    while (!fin && t < 400) begin
      a_in  = 8'($urandom);
      b_in  = 8'($urandom);
      start = poke_start && (t == 4);
      ena   = !(freeze_len > 0 && t >= 1 && t < 1 + freeze_len);
      if (rand_rdy) begin
        c_ready = ($urandom_range(0, 3) != 0);
      end else if (c_valid && c_idx == 2'(stall_idx) && scnt < stall_len) begin
        c_ready = 1'b0;
        scnt++;
      end else begin
        c_ready = 1'b1;
      end
      if (!ena) stalls++;
      else if (c_valid && !c_ready) stalls++;
      tick();
      t++;
      if (done) fin = 1'b1;
    end
    start = 1'b0; ena = 1'b1; c_ready = 1'b1;
    if (!fin) begin
      n_tests++;
      n_fail++;
      $display("FAIL job_timeout: no done within 400 cycles of accept at cycle %0d", acc_cyc);
      reset_dut();
    end else begin
      check("latency", 32'(cyc - acc_cyc), 32'(12 + stalls));
      if (exp_lat > 0) check("latency_directed", 32'(cyc - acc_cyc), 32'(exp_lat));
      check("done_busy", 32'(busy), 32'd0);
      check("done_valid", 32'(c_valid), 32'd0);
    end
  endtask

  initial begin
    int t;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(c_valid), 32'd0);
    check("rst_data", 32'(c_data), 32'd0);
    check("rst_idx", 32'(c_idx), 32'd0);
    check("rst_last", 32'(c_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    run_job(8'hAA, 8'hAA, -1, 0, 0, 1'b0, 1'b0, 12);
    run_job(8'h41, 8'hB1, -1, 0, 0, 1'b0, 1'b0, 12);
    run_job(8'h41, 8'hB1, 1, 5, 0, 1'b0, 1'b0, 17);
    run_job(8'hAA, 8'hAA, -1, 0, 4, 1'b0, 1'b0, 16);
    run_job(8'h5A, 8'hC3, -1, 0, 0, 1'b0, 1'b1, 12);

    // Reset while c10 is presented.
    model_job(8'h6C, 8'h93);
    a_in = 8'h6C; b_in = 8'h93; start = 1'b1; ena = 1'b1; c_ready = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (!(c_valid && c_idx == 2'd2) && t < 50) begin
      tick();
      t++;
    end
    c_ready = 1'b0;
    check("reach_idx2", 32'({c_valid, c_idx}), 32'h6);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(c_valid), 32'd0);
    check("arst_data", 32'(c_data), 32'd0);
    check("arst_idx", 32'(c_idx), 32'd0);
    check("arst_last", 32'(c_last), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    exp_q.delete();
`ifdef MM_SEQ_ACCUM_EN
    for (int i = 0; i < 4; i++) creg[i] = 0;
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    c_ready = 1'b1;
    tick();
    run_job(8'h41, 8'hB1, -1, 0, 0, 1'b0, 1'b0, 12);

`ifdef MM_SEQ_ACCUM_EN
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    for (int i = 0; i < 4; i++) creg[i] = 0;
    for (int j = 0; j < 16; j++) run_job(8'hAA, 8'hAA, -1, 0, 0, 1'b0, 1'b0, 12);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    for (int i = 0; i < 4; i++) creg[i] = 0;
    run_job(8'hAA, 8'hAA, -1, 0, 0, 1'b0, 1'b0, 12);
`endif

    for (int j = 0; j < 30; j++) begin
      run_job(8'($urandom), 8'($urandom), -1, 0, int'($urandom_range(0, 3)), 1'b1,
              1'($urandom_range(0, 1)), 0);
    end

    tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mm_seq_ctrl.md
# mm_seq_ctrl

Sequencing controller for the 2×2 signed matrix multiplier. It captures a packed A and B operand pair on a start strobe and time-multiplexes a single shared multiply-accumulate unit over the four dot products. It then streams the C elements out one at a time under a valid/ready handshake. It sits between the top-level I/O pins (ui_in carries A, uio_in carries B) and the output pins (uo_out carries C).

## Interface
- OUT_W, 8, width of each sign-extended C element output; must be ≥ 5.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  design enable; when low, all state is frozen.
- start  in  1  job request; sampled only in IDLE with ena high.
- a_in  in  8  matrix A, packed {a00,a01,a10,a11}, MSB first, 2-bit two's complement each (range −2..1).
- b_in  in  8  matrix B, same packing as a_in.
- busy  out  1  high from the start-accept edge until the done edge.
- c_valid  out  1  c_data/c_idx hold a valid element.
- c_ready  in  1  consumer accepts the element when c_valid && c_ready.
- c_data  out  OUT_W  current C element, signed, sign-extended.
- c_idx  out  2  element index {i,j}: 0=c00, 1=c01, 2=c10, 3=c11.
- c_last  out  1  high with c_valid on c11.
- done  out  1  one-cycle pulse on the edge that accepts c11.
- acc_clr  in  1  present only with MM_SEQ_ACCUM_EN; see Configuration.

## Operation
- FSM states: IDLE, MAC0, MAC1, OUT.
- IDLE
  - On start && ena: latch a_in and b_in, set k=0, go to MAC0.
  - start is ignored in every other state.
- MAC0: acc ← A[i][0]·B[0][j], go to MAC1.
- MAC1: acc ← acc + A[i][1]·B[1][j], go to OUT.
- OUT
  - c_valid=1 while waiting.
  - On handshake with k<3: k←k+1, go to MAC0.
  - On handshake with k=3: pulse done, go to IDLE.
- Arithmetic
  - Each product is 4-bit signed, range −2..4.
  - The sum is 5-bit signed, range −4..8.
  - c_data is the sign-extension of the sum to OUT_W.
- Output stability: while c_valid && !c_ready, c_data, c_idx and c_last hold stable.
- ena low freezes the FSM, the operand latches, the accumulator and all outputs, regardless of start or c_ready.
  - c_valid stays asserted if it was asserted.
  - A handshake does not complete while ena is low.
- Reset asserted at any time
  - State goes to IDLE immediately (asynchronously).
  - The in-flight job is discarded.
  - No done pulse is generated.
- Output reset values: all 0 (busy, c_valid, c_data, c_idx, c_last, done).

## Timing
- Start accepted at edge N.
- MAC0 at edge N+1; MAC1 at edge N+2.
- c_valid is first high after edge N+2.
- Each element takes a minimum of 3 cycles, so a job takes a minimum of 12 cycles from accept to done.
- Each cycle of c_ready low adds one cycle to the job.
- done is high for exactly the one cycle following the final handshake edge, and busy falls on that same edge.
- A new start is accepted no earlier than the cycle after done.

## Configuration
- MM_SEQ_ACCUM_EN defined
  - Adds the acc_clr port and a 4×OUT_W C register file.
  - Each job computes C ← sat(C_prev + A·B) and outputs the updated C.
  - sat clamps to the signed OUT_W range.
  - acc_clr in IDLE zeroes the register file. acc_clr is ignored while busy.
  - The register file resets to 0.
- MM_SEQ_ACCUM_EN undefined
  - No acc_clr port and no register file.
  - Each job outputs A·B only.

## Structure
- Package mm_seq_pkg holds:
  - the FSM state enum;
  - ELEM_W=2 and SUM_W=5;
  - the unpack helper that returns element (r,c) of a packed byte.
- Sub-module mm_mac is a single signed 2×2-bit multiplier plus 5-bit accumulator, with clr/en controls.
  - mm_seq_ctrl instantiates it once and owns all sequencing.

## Test plan
- All elements −2 (a_in=0xAA, b_in=0xAA), c_ready=1 → c_data=0x08 for idx 0..3; done 12 cycles after accept.
- Identity test (a_in=0x41, b_in=0xB1) → c_data = 0xFE, 0xFF, 0x00, 0x01; c_last only on idx 3.
- Backpressure: hold c_ready=0 for 5 cycles on idx 1 → c_valid and c_data stay stable; done is delayed by exactly 5 cycles.
- Freeze and ignore:
  - ena=0 for 4 cycles during MAC1 → results are unchanged versus the uninterrupted run.
  - start pulsed while busy → ignored.
- Reset mid-job: rst_n low during idx 2 OUT → all outputs 0 immediately; the next job runs correctly from idx 0.
- MM_SEQ_ACCUM_EN:
  - Two 0xAA/0xAA jobs → second job outputs 0x10.
  - 16 jobs → 0x7F (saturated).
  - acc_clr, then one job → 0x08.
